// File: rtl/encoder_step_arbiter.sv
// encoder_step_arbiter: per-channel signed pending-step counters feeding a
// single round-robin grant per cycle that moves one channel value by INC_STEP.
module encoder_step_arbiter #(
    parameter int DATA_LEN = 8,
    parameter int INC_STEP = 1,
    parameter int N_CH     = 3,
    parameter int PEND_W   = 4,
    parameter int WRAP     = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            step_up,
    input  logic [N_CH-1:0]            step_dn,
    input  logic [N_CH-1:0]            clear,
    output logic [N_CH*DATA_LEN-1:0]   value,
    output logic [N_CH-1:0]            upd,
    output logic [N_CH-1:0]            drop,
    output logic                       busy
);

    localparam int PTR_W = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam bit SAT   = (WRAP == 0);
    localparam logic [DATA_LEN:0]        INC_EXT = (DATA_LEN+1)'(INC_STEP);
    localparam logic signed [PEND_W+1:0] P_ONE   = (PEND_W+2)'(1);
    localparam logic signed [PEND_W+1:0] P_MAX   = (PEND_W+2)'((1 << (PEND_W-1)) - 1);
    localparam logic signed [PEND_W+1:0] P_MIN   = (PEND_W+2)'(-(1 << (PEND_W-1)));

    logic        [DATA_LEN-1:0] r_val  [N_CH];
    logic signed [PEND_W-1:0]   r_pend [N_CH];
    logic        [N_CH-1:0]     r_upd;
    logic        [N_CH-1:0]     r_drop;
    logic        [PTR_W-1:0]    r_ptr;

    logic        [DATA_LEN-1:0] w_val_nxt  [N_CH];
    logic signed [PEND_W-1:0]   w_pend_nxt [N_CH];
    logic        [N_CH-1:0]     w_upd_nxt;
    logic        [N_CH-1:0]     w_drop_nxt;
    logic        [N_CH-1:0]     w_cand;
    logic        [N_CH-1:0]     w_grant;
    logic        [PTR_W-1:0]    w_gidx;
    logic                       w_any;

    // Candidates: registered pending work on a channel not being cleared.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_cand[i] = (r_pend[i] != '0) && !clear[i];
        end
    end

    // Round-robin search from r_ptr upward; first candidate wins.
    always_comb begin
        int idx;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        idx     = 0;
        for (int o = 0; o < N_CH; o++) begin
            idx = int'(r_ptr) + o;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!w_any && w_cand[idx]) begin
                w_any        = 1'b1;
                w_gidx       = PTR_W'(idx);
                w_grant[idx] = 1'b1;
            end
        end
    end

    // Per-channel next value, pending count and drop flag.
    always_comb begin
        logic signed [PEND_W+1:0] ps;
        logic        [DATA_LEN:0] ext;
        logic        [DATA_LEN-1:0] nv;
        for (int i = 0; i < N_CH; i++) begin
            w_val_nxt[i]  = r_val[i];
            w_pend_nxt[i] = r_pend[i];
            w_upd_nxt[i]  = 1'b0;
            w_drop_nxt[i] = r_drop[i];
            ps  = {{2{r_pend[i][PEND_W-1]}}, r_pend[i]};
            ext = '0;
            nv  = r_val[i];
            if (step_up[i]) ps = ps + P_ONE;
            if (step_dn[i]) ps = ps - P_ONE;
            if (w_grant[i]) begin
                // A granted channel always has nonzero pend, so the sign bit alone picks direction.
                if (!r_pend[i][PEND_W-1]) begin
                    ps  = ps - P_ONE;
                    ext = {1'b0, r_val[i]} + INC_EXT;
                    nv  = (ext[DATA_LEN] && SAT) ? '1 : ext[DATA_LEN-1:0];
                end else begin
                    ps  = ps + P_ONE;
                    ext = {1'b0, r_val[i]} - INC_EXT;
                    nv  = (ext[DATA_LEN] && SAT) ? '0 : ext[DATA_LEN-1:0];
                end
                w_upd_nxt[i] = (nv != r_val[i]);
                w_val_nxt[i] = nv;
            end
            if (ps > P_MAX) begin
                w_pend_nxt[i] = P_MAX[PEND_W-1:0];
                w_drop_nxt[i] = 1'b1;
            end else if (ps < P_MIN) begin
                w_pend_nxt[i] = P_MIN[PEND_W-1:0];
                w_drop_nxt[i] = 1'b1;
            end else begin
                w_pend_nxt[i] = ps[PEND_W-1:0];
            end
            if (clear[i]) begin
                w_val_nxt[i]  = '0;
                w_pend_nxt[i] = '0;
                w_upd_nxt[i]  = 1'b0;
                w_drop_nxt[i] = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_val[i]  <= '0;
                r_pend[i] <= '0;
            end
            r_upd  <= '0;
            r_drop <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_val[i]  <= w_val_nxt[i];
                r_pend[i] <= w_pend_nxt[i];
            end
            r_upd  <= w_upd_nxt;
            r_drop <= w_drop_nxt;
        end
    end

    // Round-robin pointer moves just past the granted channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == PTR_W'(N_CH-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // Output packing and busy from registered pend.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            value[i*DATA_LEN +: DATA_LEN] = r_val[i];
            busy = busy | (r_pend[i] != '0);
        end
    end

    assign upd  = r_upd;
    assign drop = r_drop;

endmodule

// File: tb/tb_encoder_step_arbiter.sv
// Bench for encoder_step_arbiter: saturating and wrapping instances share stimulus,
// each checked every cycle against an integer model, plus pinned scenarios.
module tb_encoder_step_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] step_up = '0;
    logic [N-1:0] step_dn = '0;
    logic [N-1:0] clear   = '0;

    logic [N*8-1:0] v0, v1;
    logic [N-1:0]   u0, u1, d0, d1;
    logic           b0, b1;

    int total = 0;
    int bad   = 0;

    // model state per instance (0: saturate, 1: wrap)
    int m_val  [2][N];
    int m_pend [2][N];
    int m_upd  [2][N];
    int m_drop [2][N];
    int m_ptr  [2];

    encoder_step_arbiter #(.DATA_LEN(8), .INC_STEP(1), .N_CH(N), .PEND_W(4), .WRAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .step_up(step_up), .step_dn(step_dn), .clear(clear),
        .value(v0), .upd(u0), .drop(d0), .busy(b0));

    encoder_step_arbiter #(.DATA_LEN(8), .INC_STEP(1), .N_CH(N), .PEND_W(4), .WRAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .step_up(step_up), .step_dn(step_dn), .clear(clear),
        .value(v1), .upd(u1), .drop(d1), .busy(b1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int gval(input int w, input int ch);
        logic [N*8-1:0] v;
        v = (w == 0) ? v0 : v1;
        return int'((v >> (8*ch)) & 24'hFF);
    endfunction

    function automatic int gupd(input int w, input int ch);
        return int'((w == 0) ? u0[ch] : u1[ch]);
    endfunction

    function automatic int gdrop(input int w, input int ch);
        return int'((w == 0) ? d0[ch] : d1[ch]);
    endfunction

    // Reference model: search from the pointer for pending work, move the value one step
    // toward the sign of pending, then account new requests with saturation.
    always @(posedge clk or negedge reset_n) begin
        int g, nv, s, sg;
        if (!reset_n) begin
            for (int w = 0; w < 2; w++) begin
                m_ptr[w] = 0;
                for (int i = 0; i < N; i++) begin
                    m_val[w][i] = 0; m_pend[w][i] = 0; m_upd[w][i] = 0; m_drop[w][i] = 0;
                end
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                g = -1;
                for (int o = 0; o < N; o++) begin
                    if (g < 0 && m_pend[w][(m_ptr[w]+o)%N] != 0 && !clear[(m_ptr[w]+o)%N])
                        g = (m_ptr[w]+o) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (clear[i]) begin
                        m_val[w][i] = 0; m_pend[w][i] = 0; m_upd[w][i] = 0; m_drop[w][i] = 0;
                    end else begin
                        m_upd[w][i] = 0;
                        sg = 0;
                        if (i == g) begin
                            sg = (m_pend[w][i] > 0) ? 1 : -1;
                            nv = m_val[w][i] + sg;
                            if (w == 1) nv = (nv + 256) % 256;
                            else if (nv > 255) nv = 255;
                            else if (nv < 0) nv = 0;
                            m_upd[w][i] = (nv != m_val[w][i]) ? 1 : 0;
                            m_val[w][i] = nv;
                        end
                        s = m_pend[w][i] + int'(step_up[i]) - int'(step_dn[i]) - sg;
                        if (s > 7) begin s = 7; m_drop[w][i] = 1; end
                        if (s < -8) begin s = -8; m_drop[w][i] = 1; end
                        m_pend[w][i] = s;
                    end
                end
                if (g >= 0) m_ptr[w] = (g + 1) % N;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(posedge clk) begin
        int bz;
        #2;
        if (reset_n) begin
            for (int w = 0; w < 2; w++) begin
                bz = 0;
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("w%0d_value%0d", w, i), gval(w, i), m_val[w][i]);
                    chk($sformatf("w%0d_upd%0d", w, i), gupd(w, i), m_upd[w][i]);
                    chk($sformatf("w%0d_drop%0d", w, i), gdrop(w, i), m_drop[w][i]);
                    if (m_pend[w][i] != 0) bz = 1;
                end
                chk($sformatf("w%0d_busy", w), int'((w == 0) ? b0 : b1), bz);
            end
        end
    end

    task automatic drive(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] c);
        @(negedge clk);
        step_up = u; step_dn = d; clear = c;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic rst_pulse();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_value0", int'(v0), 0);
        chk("rst_value1", int'(v1), 0);
        chk("rst_upd", int'({u0, u1}), 0);
        chk("rst_drop", int'({d0, d1}), 0);
        chk("rst_busy", int'({b0, b1}), 0);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_to_255(input int ch);
        rst_pulse();
        repeat (255) drive(3'(1 << ch), '0, '0);
        drive('0, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        chk("full_sat", gval(0, ch), 255);
        chk("full_wrap", gval(1, ch), 255);
        drive(3'(1 << ch), '0, '0);
        drive('0, '0, '0);
        after_edge();
        chk("top_clamp_value", gval(0, ch), 255);
        chk("top_clamp_upd", gupd(0, ch), 0);
        chk("top_wrap_value", gval(1, ch), 0);
        chk("top_wrap_upd", gupd(1, ch), 1);
    endtask

    initial begin
        #12 reset_n = 1'b1;

        // single step on ch0
        rst_pulse();
        drive(3'b001, '0, '0);
        drive('0, '0, '0);
        after_edge();
        chk("single_value", gval(0, 0), 1);
        chk("single_upd", gupd(0, 0), 1);
        chk("single_busy", int'(b0), 0);
        after_edge();
        chk("single_upd_gone", gupd(0, 0), 0);

        // three simultaneous requests granted 0,1,2
        rst_pulse();
        drive(3'b111, '0, '0);
        drive('0, '0, '0);
        after_edge();
        chk("rr_e1_upd", int'(u0), 1);
        chk("rr_e1_val0", gval(0, 0), 1);
        after_edge();
        chk("rr_e2_upd", int'(u0), 2);
        chk("rr_e2_val1", gval(0, 1), 1);
        after_edge();
        chk("rr_e3_upd", int'(u0), 4);
        chk("rr_e3_val2", gval(0, 2), 1);
        chk("rr_e3_busy", int'(b0), 0);

        // decrement at zero clamps silently
        rst_pulse();
        drive('0, 3'b010, '0);
        drive('0, '0, '0);
        after_edge();
        chk("bot_clamp_value", gval(0, 1), 0);
        chk("bot_clamp_upd", gupd(0, 1), 0);
        chk("bot_clamp_busy", int'(b0), 0);

        // top-of-range behaviour on ch1 and ch2
        run_to_255(1);
        run_to_255(2);

        // pending saturation with all channels contending
        rst_pulse();
        repeat (12) drive(3'b111, '0, '0);
        drive('0, '0, '0);
        chk("model_pend0_sat", m_pend[0][0], 7);
        chk("sat_drop0", int'(d0[0]), 1);
        drive('0, '0, 3'b001);
        drive('0, '0, '0);
        after_edge();
        chk("clear_value0", gval(0, 0), 0);
        chk("clear_drop0", int'(d0[0]), 0);

        // reset mid-operation with pending work
        rst_pulse();
        drive(3'b111, '0, '0);
        drive('0, '0, '0);
        rst_pulse();
        after_edge();
        chk("post_rst_upd", int'(u0), 0);
        chk("post_rst_value", int'(v0), 0);
        chk("post_rst_busy", int'(b0), 0);

        // randomized traffic
        rst_pulse();
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] c;
            c = '0;
            for (int i = 0; i < N; i++) c[i] = ($urandom_range(0, 15) == 0);
            drive(3'($urandom), 3'($urandom), c);
            if (k == 300) rst_pulse();
        end
        drive('0, '0, '0);
        repeat (20) @(posedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
